// File: rtl/cnt_ctrl.sv
// rtl/cnt_ctrl.sv - count-enable and counter-clear generator for the 64-bit timer
module cnt_ctrl #(
    parameter int MAX_DIV = 8,
    parameter int PRE_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       timer_en,
    input  logic       div_en,
    input  logic [3:0] div_val,
    input  logic       debug_mode,
    input  logic       halt_req,
    output logic       cnt_en,
    output logic       rst_cnt,
    output logic       halt_ack
);

    localparam logic [3:0] MAX_DV = 4'(MAX_DIV);

    logic [3:0]       dv_eff;
    logic [3:0]       dv_q;
    logic [PRE_W:0]   span;
    logic [PRE_W-1:0] limit;
    logic [PRE_W-1:0] pre_cnt;
    logic             halt;
    logic             ten_q;
    logic             dv_same;
    logic             at_limit;

    // Clamp the divide exponent, derive the prescaler terminal value and the
    // combinational outputs. span is one bit wider so 2^PRE_W does not wrap
    // before the subtraction.
    always_comb begin
        dv_eff   = (div_val > MAX_DV) ? MAX_DV : div_val;
        span     = (PRE_W + 1)'(1) << dv_eff;
        limit    = PRE_W'(span - (PRE_W + 1)'(1));
        halt     = debug_mode & halt_req;
        dv_same  = (dv_eff == dv_q);
        at_limit = (pre_cnt == limit);
        // A divide change suppresses the pulse in the cycle it is seen.
        cnt_en   = timer_en & ~halt & (~div_en | (at_limit & dv_same));
        // Halt deliberately does not mask the disable clear.
        rst_cnt  = ten_q & ~timer_en;
    end

    // Prescaler: restart on disable or divide change, freeze on halt, else wrap at limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (!timer_en || !div_en || !dv_same) begin
            pre_cnt <= '0;
        end else if (halt) begin
            pre_cnt <= pre_cnt;
        end else if (at_limit) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // History registers: previous exponent, previous enable, and the halt acknowledge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q     <= '0;
            ten_q    <= 1'b0;
            halt_ack <= 1'b0;
        end else begin
            dv_q     <= dv_eff;
            ten_q    <= timer_en;
            halt_ack <= halt;
        end
    end

endmodule

// File: tb/tb_cnt_ctrl.sv
// tb/tb_cnt_ctrl.sv - scoreboard bench for cnt_ctrl
module tb_cnt_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       timer_en = 1'b0;
    logic       div_en = 1'b0;
    logic [3:0] div_val = 4'd0;
    logic       debug_mode = 1'b0;
    logic       halt_req = 1'b0;
    logic       cnt_en;
    logic       rst_cnt;
    logic       halt_ack;

    typedef struct {
        logic  ce;
        logic  rc;
        logic  ha;
        string nm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;

    cnt_ctrl #(.MAX_DIV(8), .PRE_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .timer_en   (timer_en),
        .div_en     (div_en),
        .div_val    (div_val),
        .debug_mode (debug_mode),
        .halt_req   (halt_req),
        .cnt_en     (cnt_en),
        .rst_cnt    (rst_cnt),
        .halt_ack   (halt_ack)
    );

    always #5 clk = ~clk;

    // Monitor: one expected output triple per cycle, compared mid-cycle.
    always begin
        @(negedge clk);
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if ({cnt_en, rst_cnt, halt_ack} !== {mon_e.ce, mon_e.rc, mon_e.ha}) begin
                failures++;
                $display("FAIL %s t=%0t: got cnt_en=%b rst_cnt=%b halt_ack=%b, expected cnt_en=%b rst_cnt=%b halt_ack=%b",
                         mon_e.nm, $time, cnt_en, rst_cnt, halt_ack, mon_e.ce, mon_e.rc, mon_e.ha);
            end
        end
    end

    // Drive one cycle of inputs just after the rising edge and queue the expected outputs.
    task automatic step(input logic rn, input logic te, input logic de, input logic [3:0] dv,
                        input logic dm, input logic hr,
                        input logic ece, input logic erc, input logic eha, input string nm);
        @(posedge clk);
        #1;
        rst_n      = rn;
        timer_en   = te;
        div_en     = de;
        div_val    = dv;
        debug_mode = dm;
        halt_req   = hr;
        sb.push_back('{ece, erc, eha, nm});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        step(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, "reset");
        step(0, 0, 0, 4'd0, 0, 0, 0, 0, 0, "reset");

        // No prescaler: count every cycle.
        for (int i = 0; i < 10; i++)
            step(1, 1, 0, 4'd0, 0, 0, 1, 0, 0, "nodiv");
        step(1, 0, 0, 4'd0, 0, 0, 0, 1, 0, "fall_nodiv");
        step(1, 0, 1, 4'd2, 0, 0, 0, 0, 0, "idle_dv2");

        // Divide by 4: first pulse in the 4th cycle, 5 pulses in 20.
        for (int i = 0; i < 20; i++)
            step(1, 1, 1, 4'd2, 0, 0, (i % 4) == 3, 0, 0, "div4");
        step(1, 0, 1, 4'd12, 0, 0, 0, 1, 0, "fall_div4");

        // div_val=12 clamps to 256.
        for (int i = 0; i < 512; i++)
            step(1, 1, 1, 4'd12, 0, 0, (i % 256) == 255, 0, 0, "div12_clamp");
        step(1, 0, 1, 4'd8, 0, 0, 0, 1, 0, "fall_div12");

        // div_val=8 gives the same 256 period.
        for (int i = 0; i < 512; i++)
            step(1, 1, 1, 4'd8, 0, 0, (i % 256) == 255, 0, 0, "div256");
        step(1, 0, 1, 4'd3, 0, 0, 0, 1, 0, "fall_div256");

        // Divide by 8, halt for 5 cycles at pre_cnt=5, then halt_req without debug_mode.
        for (int i = 0; i <= 36; i++)
            step(1, 1, 1, 4'd3,
                 (i >= 5 && i <= 9),
                 (i >= 5 && i <= 9) || (i >= 25 && i <= 29),
                 (i == 12) || (i == 20) || (i == 28) || (i == 36),
                 0,
                 (i >= 6 && i <= 10),
                 "halt_div8");

        // Disable coinciding with halt: clear still pulses, acknowledge follows.
        step(1, 0, 1, 4'd3, 1, 1, 0, 1, 0, "fall_with_halt");
        step(1, 0, 1, 4'd3, 0, 0, 0, 0, 1, "halt_ack_tail");
        step(1, 0, 1, 4'd1, 0, 0, 0, 0, 0, "idle_dv1");

        // Divide change 1->3 on a would-be pulse cycle.
        for (int i = 0; i < 20; i++)
            step(1, 1, 1, (i < 3) ? 4'd1 : 4'd3, 0, 0,
                 (i == 1) || (i == 11) || (i == 19), 0, 0, "div_change");

        // Async reset mid-period with halt_ack about to rise.
        step(1, 1, 1, 4'd3, 1, 1, 0, 0, 0, "pre_reset_halt");
        step(0, 1, 1, 4'd3, 0, 0, 0, 0, 0, "async_reset");
        step(0, 1, 1, 4'd3, 0, 0, 0, 0, 0, "async_reset_hold");
        for (int i = 0; i <= 8; i++)
            step(1, 1, 1, 4'd3, 0, 0, i == 8, 0, 0, "after_reset");

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cnt_ctrl.md
# cnt_ctrl

Count-enable generator that sits directly upstream of the 64-bit timer counter. It drives the counter's `cnt_en` and `rst_cnt` inputs from the timer control register fields (`timer_en`, `div_en`, `div_val`) and from the debug halt handshake. It contains an internal prescaler that turns the system clock into a 1-cycle count-enable pulse every 2^div_val cycles.

## Interface
- `MAX_DIV`, 8: largest effective `div_val`; larger requests clamp to this value.
- `PRE_W`, 8: prescaler width; must satisfy 2^PRE_W ≥ 2^MAX_DIV.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `timer_en` input 1: timer enable (TCR.timer_en).
- `div_en` input 1: prescaler enable (TCR.div_en).
- `div_val` input 4: divide exponent (TCR.div_val); the division ratio is 2^div_val.
- `debug_mode` input 1: CPU is in debug mode.
- `halt_req` input 1: halt request from the debug controller.
- `cnt_en` output 1: count-enable pulse to the counter.
- `rst_cnt` output 1: synchronous counter clear to the counter.
- `halt_ack` output 1: the counter is frozen.

## Operation
- Effective exponent: `dv_eff = (div_val > MAX_DIV) ? MAX_DIV : div_val`.
- Terminal value: `limit = 2^dv_eff - 1`, computed in PRE_W bits.
- Halt condition: `halt = debug_mode & halt_req`. It is combinational and takes effect in the same cycle.
- Internal prescaler register `pre_cnt[PRE_W-1:0]` is updated with this priority:
  1. `timer_en==0`, `div_en==0`, or `dv_eff` differs from the registered previous value `dv_q` → `pre_cnt` <= 0.
  2. `halt` → `pre_cnt` holds.
  3. `pre_cnt==limit` → `pre_cnt` <= 0 (wrap-around).
  4. Otherwise → `pre_cnt` <= `pre_cnt + 1`.
- `dv_q` <= `dv_eff` every cycle.
- `cnt_en` is combinational:
  - `timer_en & ~halt & ~div_en` → 1 every cycle.
  - `timer_en & ~halt & div_en` → 1 only when `pre_cnt==limit` and `dv_eff==dv_q`.
  - Otherwise → 0.
  - With `dv_eff==0`, `limit==0`, so `cnt_en` is high every cycle. This is the same behaviour as `div_en=0`.
- Falling-edge detect on `timer_en`:
  - `ten_q` <= `timer_en` each cycle.
  - `rst_cnt = ten_q & ~timer_en`, a 1-cycle pulse. The counter therefore clears after the timer is disabled.
  - A rising edge produces no pulse.
- `halt_ack` <= `halt`, registered. It deasserts one cycle after `halt` drops.
- No state machine beyond the prescaler. The implicit states are idle (`timer_en=0`), running, and halted.

## Timing
- Reset values:
  - `pre_cnt=0`, `dv_q=0`, `ten_q=0`, `halt_ack=0`.
  - `cnt_en=0` and `rst_cnt=0` while `timer_en=0`.
- Latency:
  - `timer_en` rising with `div_en=0`: `cnt_en` is high in the same cycle.
  - With `div_en=1`: the first `cnt_en` occurs in the 2^dv_eff-th cycle after enable. The prescaler starts at 0 and pulses when it equals `limit`.
  - `halt`: `cnt_en` is low in the same cycle; `halt_ack` rises on the next edge.
- Changing `div_val` mid-count:
  - The change cycle suppresses `cnt_en`.
  - `pre_cnt` restarts at 0 on the next edge.
  - The new period applies from then on.
- Simultaneous `timer_en` fall and `halt`: `rst_cnt` still pulses and `cnt_en=0`. Halt never masks `rst_cnt`.
- Halt release: counting resumes from the held `pre_cnt` with no lost or extra pulse.
- Async reset mid-period: all registers clear immediately. After release, counting starts from `pre_cnt=0`.
- `debug_mode=0` with `halt_req=1`: no halt, `halt_ack` stays 0.

## Test plan
- Reset, then `timer_en=1`, `div_en=0` → `cnt_en=1` for 10 consecutive cycles; `rst_cnt=0`; `halt_ack=0`.
- `timer_en=1`, `div_en=1`, `div_val=2` → `cnt_en` high once every 4 cycles. First pulse in cycle 4 after enable; 5 pulses in 20 cycles.
- `div_val=12` with `div_en=1` → period clamps to 256 cycles, identical to `div_val=8`.
- Run with `div_val=3`, assert `debug_mode=1` and `halt_req=1` for 5 cycles when `pre_cnt=5` → `cnt_en=0` and `pre_cnt` stays 5. `halt_ack` is high from the next cycle until 1 cycle after release. The next pulse comes 2 cycles after release. Repeat with `debug_mode=0` → no effect.
- While counting, drop `timer_en` → `rst_cnt` is 1 for exactly 1 cycle, `cnt_en=0`, and `pre_cnt` is 0 on the next cycle. Re-enabling produces no `rst_cnt`.
- Change `div_val` 1→3 when `pre_cnt=1` (a would-be pulse cycle) → no pulse that cycle; the next pulse comes 8 cycles later. Assert `rst_n=0` mid-period → all outputs drop to 0 asynchronously.
